// File: rtl/alarm_minigame.sv
// alarm_minigame: "dial the digit" wake-up puzzle. The player must match
// ROUNDS consecutive random target digits, each within TIMEOUT_SEC seconds,
// before minigame_done pulses and the alarm can be silenced.
module alarm_minigame #(
  parameter int ROUNDS        = 3,
  parameter int TICKS_PER_SEC = 1000,
  parameter int TIMEOUT_SEC   = 9
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_confirm,
  output logic       busy,
  output logic [3:0] target,
  output logic [3:0] guess,
  output logic [2:0] round_cnt,
  output logic [3:0] time_left,
  output logic       wrong,
  output logic       minigame_done
);

  localparam int              PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]      TIME_INIT = 4'(TIMEOUT_SEC);
  localparam logic [2:0]      ROUNDS_W  = 3'(ROUNDS);
  localparam logic [7:0]      LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          start_q;              // start as seen last cycle, for edge detection
  logic [7:0]    lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    target_q, target_d;
  logic [3:0]    guess_q, guess_d;
  logic [2:0]    round_q, round_d;
  logic [3:0]    time_q, time_d;
  logic          busy_q, busy_d;
  logic          wrong_q, wrong_d;
  logic          done_q, done_d;

  logic          tick_wrap;
  logic          start_rise;

  // Fold a 4-bit LFSR nibble into a decimal digit 0..9.
  function automatic logic [3:0] to_digit(input logic [3:0] d);
    return (d >= 4'd10) ? d - 4'd10 : d;
  endfunction

  assign tick_wrap  = (presc_q == PRESC_MAX);
  assign start_rise = start && !start_q;

  // State register and all datapath registers, synchronous active-low reset.
  always_ff @(posedge MCLK) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!RESET) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      presc_q  <= '0;
      target_q <= '0;
      guess_q  <= '0;
      round_q  <= '0;
      time_q   <= '0;
      busy_q   <= 1'b0;
      wrong_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      lfsr_q   <= lfsr_d;
      presc_q  <= presc_d;
      target_q <= target_d;
      guess_q  <= guess_d;
      round_q  <= round_d;
      time_q   <= time_d;
      busy_q   <= busy_d;
      wrong_q  <= wrong_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath logic for the game FSM.
  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    state_d  = state_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    presc_d  = presc_q;
    target_d = target_q;
    guess_d  = guess_q;
    round_d  = round_q;
    time_d   = time_q;
    busy_d   = busy_q;
    wrong_d  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_rise) state_d = LOAD;
      end

      LOAD: begin
        if (!start) begin
          // Alarm stage withdrew its enable: quietly abandon the game.
          state_d = IDLE;
          busy_d  = 1'b0;
          round_d = '0;
        end else begin
          target_d = to_digit(lfsr_q[3:0]);
          guess_d  = '0;
          time_d   = TIME_INIT;
          presc_d  = '0;
          busy_d   = 1'b1;
          state_d  = PLAY;
        end
      end

      PLAY: begin
        if (!start) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          round_d = '0;
        end else if (btn_confirm) begin
          // Confirm wins over btn_up and over a coincident timeout; the
          // registered guess is what gets judged.
          if (guess_q == target_q) begin
            if (round_q + 3'd1 == ROUNDS_W) begin
              round_d = ROUNDS_W;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              round_d = round_q + 3'd1;
              state_d = LOAD;
            end
          end else begin
            wrong_d = 1'b1;
            round_d = '0;
            state_d = LOAD;
          end
        end else begin
          if (btn_up) guess_d = (guess_q == 4'd9) ? 4'd0 : guess_q + 4'd1;
          if (tick_wrap) begin
            presc_d = '0;
            if (time_q == 4'd1) begin
              time_d  = '0;
              wrong_d = 1'b1;
              round_d = '0;
              state_d = LOAD;
            end else begin
              time_d = time_q - 4'd1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        round_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy          = busy_q;
  assign target        = target_q;
  assign guess         = guess_q;
  assign round_cnt     = round_q;
  assign time_left     = time_q;
  assign wrong         = wrong_q;
  assign minigame_done = done_q;

endmodule

// File: tb/tb_alarm_minigame.sv
// Directed bench for alarm_minigame with a small scoreboard: expectations
// are queued while stimulus is set up and popped as the DUT outputs are
// sampled 1 ns after each rising clock edge.
module tb_alarm_minigame;

  localparam int ROUNDS = 2;
  localparam int TICKS  = 4;
  localparam int TMO    = 3;

  logic       MCLK = 1'b0;
  logic       RESET;
  logic       start;
  logic       btn_up;
  logic       btn_confirm;
  logic       busy;
  logic [3:0] target;
  logic [3:0] guess;
  logic [2:0] round_cnt;
  logic [3:0] time_left;
  logic       wrong;
  logic       minigame_done;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] m_lfsr;
  logic [3:0] cur_t;
  string      tag_q[$];
  logic [7:0] exp_q[$];

  always #5 MCLK = ~MCLK;

  alarm_minigame #(
    .ROUNDS       (ROUNDS),
    .TICKS_PER_SEC(TICKS),
    .TIMEOUT_SEC  (TMO)
  ) dut (
    .MCLK         (MCLK),
    .RESET        (RESET),
    .start        (start),
    .btn_up       (btn_up),
    .btn_confirm  (btn_confirm),
    .busy         (busy),
    .target       (target),
    .guess        (guess),
    .round_cnt    (round_cnt),
    .time_left    (time_left),
    .wrong        (wrong),
    .minigame_done(minigame_done)
  );

  // Reference random source: x^8+x^6+x^5+x^4+1, seeded 0xA5 on reset.
  always @(posedge MCLK) begin
    if (!RESET) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [3:0] digit(input logic [7:0] s);
    logic [3:0] d;
    d = s[3:0];
    return (d > 4'd9) ? d - 4'd10 : d;
  endfunction

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [7:0] obs);
    string      tag;
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=none", obs);
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic ups(input int n);
    repeat (n) begin
      btn_up = 1'b1;
      tick();
      btn_up = 1'b0;
    end
  endtask

  // LOAD cycle: new target comes from the LFSR value present at the edge.
  task automatic load(input logic [2:0] exp_round);
    cur_t = digit(m_lfsr);
    expect_out("load_busy", 8'd1);
    expect_out("load_target", {4'd0, cur_t});
    expect_out("load_guess", 8'd0);
    expect_out("load_time", 8'(TMO));
    expect_out("load_round", {5'd0, exp_round});
    expect_out("load_wrong", 8'd0);
    tick();
    check(busy); check(target); check(guess);
    check(time_left); check(round_cnt); check(wrong);
  endtask

  task automatic win_round(input logic [2:0] exp_round, input logic exp_done);
    ups(int'(cur_t));
    expect_out("dialled_guess", {4'd0, cur_t});
    check(guess);
    btn_confirm = 1'b1;
    expect_out("win_round", {5'd0, exp_round});
    expect_out("win_wrong", 8'd0);
    expect_out("win_done", {7'd0, exp_done});
    expect_out("win_busy", 8'd1);
    tick();
    btn_confirm = 1'b0;
    check(round_cnt); check(wrong); check(minigame_done); check(busy);
  endtask

  initial begin
    RESET = 1'b0; start = 1'b0; btn_up = 1'b0; btn_confirm = 1'b0;
    cur_t = '0;

    // 1. reset and idle
    repeat (3) tick();
    RESET = 1'b1;
    expect_out("rst_busy", 0);  expect_out("rst_target", 0); expect_out("rst_guess", 0);
    expect_out("rst_round", 0); expect_out("rst_time", 0);   expect_out("rst_wrong", 0);
    expect_out("rst_done", 0);
    check(busy); check(target); check(guess); check(round_cnt);
    check(time_left); check(wrong); check(minigame_done);
    btn_up = 1'b1;
    expect_out("idle_up_guess", 0);
    tick();
    btn_up = 1'b0;
    check(guess);
    btn_confirm = 1'b1;
    expect_out("idle_cf_wrong", 0); expect_out("idle_cf_busy", 0);
    tick();
    btn_confirm = 1'b0;
    check(wrong); check(busy);

    // 2. win path, start latency
    start = 1'b1;
    expect_out("start_edge_busy", 0);
    tick();
    check(busy);
    load(3'd0);
    win_round(3'd1, 1'b0);
    load(3'd1);
    win_round(3'(ROUNDS), 1'b1);
    expect_out("done_fall", 0);   expect_out("done_busy", 0); expect_out("done_round", 0);
    expect_out("done_target", {4'd0, cur_t}); expect_out("done_guess", {4'd0, cur_t});
    tick();
    check(minigame_done); check(busy); check(round_cnt); check(target); check(guess);
    // start held high after a win: no new game
    repeat (4) begin
      expect_out("held_busy", 0); expect_out("held_done", 0);
      tick();
      check(busy); check(minigame_done);
    end

    // 3. wrong guess with a streak of one
    start = 1'b0; tick();
    start = 1'b1; tick();
    load(3'd0);
    win_round(3'd1, 1'b0);
    load(3'd1);
    ups((int'(cur_t) + 9) % 10);
    btn_confirm = 1'b1;
    expect_out("wrong_pulse", 1); expect_out("wrong_round", 0); expect_out("wrong_done", 0);
    tick();
    btn_confirm = 1'b0;
    check(wrong); check(round_cnt); check(minigame_done);
    load(3'd0);

    // 4. timeout: 3,2,1,0 at TICKS spacing, streak cleared
    win_round(3'd1, 1'b0);
    load(3'd1);
    repeat (3) tick();
    expect_out("tmo_t3", 3); check(time_left);
    tick();
    expect_out("tmo_t2", 2); check(time_left);
    repeat (4) tick();
    expect_out("tmo_t1", 1); check(time_left);
    repeat (3) tick();
    expect_out("tmo_pre_wrong", 0); check(wrong);
    expect_out("tmo_t0", 0); expect_out("tmo_wrong", 1); expect_out("tmo_round", 0);
    tick();
    check(time_left); check(wrong); check(round_cnt);
    load(3'd0);

    // 5a. btn_up together with a correct confirm
    ups(int'(cur_t));
    btn_up = 1'b1; btn_confirm = 1'b1;
    expect_out("sim_guess_held", {4'd0, cur_t}); expect_out("sim_round", 1); expect_out("sim_wrong", 0);
    tick();
    btn_up = 1'b0; btn_confirm = 1'b0;
    check(guess); check(round_cnt); check(wrong);
    load(3'd1);

    // 5b. guess wraps 9 -> 0, then the round times out
    ups(9);
    expect_out("wrap_g9", 9); check(guess);
    ups(1);
    expect_out("wrap_g0", 0); check(guess);
    tick();
    expect_out("wrap_tmo_wrong", 1); expect_out("wrap_tmo_round", 0);
    tick();
    check(wrong); check(round_cnt);
    load(3'd0);

    // 5c. correct confirm on the timeout edge
    ups(int'(cur_t));
    repeat (11 - int'(cur_t)) tick();
    expect_out("race_pre_t1", 1); check(time_left);
    btn_confirm = 1'b1;
    expect_out("race_wrong", 0); expect_out("race_round", 1); expect_out("race_done", 0);
    tick();
    btn_confirm = 1'b0;
    check(wrong); check(round_cnt); check(minigame_done);
    load(3'd1);

    // 6. abort mid-PLAY, then re-trigger
    repeat (2) tick();
    start = 1'b0;
    expect_out("abort_busy", 0); expect_out("abort_done", 0);
    expect_out("abort_wrong", 0); expect_out("abort_round", 0);
    tick();
    check(busy); check(minigame_done); check(wrong); check(round_cnt);
    repeat (2) tick();
    expect_out("abort_stay", 0); check(busy);
    start = 1'b1;
    expect_out("retrig_edge_busy", 0);
    tick();
    check(busy);
    load(3'd0);

    // reset in the middle of a game
    ups(2);
    RESET = 1'b0;
    expect_out("mid_rst_busy", 0);  expect_out("mid_rst_target", 0); expect_out("mid_rst_guess", 0);
    expect_out("mid_rst_round", 0); expect_out("mid_rst_time", 0);   expect_out("mid_rst_wrong", 0);
    expect_out("mid_rst_done", 0);
    tick();
    check(busy); check(target); check(guess); check(round_cnt);
    check(time_left); check(wrong); check(minigame_done);
    RESET = 1'b1; start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    load(3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
